// File: rtl/rename_nway_pkg.sv
// Shared types and decode helpers for the N-wide rename stage.
// Uop physical-index fields are sized for PREG_W = UopPregW (33..64 physical registers).
package rename_nway_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam int unsigned UopPregW = 6;

    typedef struct packed {
        logic                valid;
        logic [6:0]          opcode;
        logic [2:0]          alu_op;
        logic [31:0]         imm;
        logic [UopPregW-1:0] prs1;
        logic [UopPregW-1:0] prs2;
        logic [UopPregW-1:0] prd;
        logic [UopPregW-1:0] old_prd;
    } uop_t;

    function automatic logic writes_rd(input logic [6:0] op);
        return (op == OP_RTYPE) || (op == OP_IALU) || (op == OP_LOAD);
    endfunction

    function automatic logic reads_rs1(input logic [6:0] op);
        return writes_rd(op) || (op == OP_STORE);
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return (op == OP_RTYPE) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/rename_nway_if.sv
// Decode-side and dispatch-side bundle of the rename stage; master drives the decode inputs.
interface rename_nway_if #(
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned PHYS_REGS = 64,
    parameter int unsigned AREG_W    = 5,
    parameter int unsigned PREG_W    = 6
);
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_lane_valid;
    logic [WIDTH*AREG_W-1:0]  in_rs1;
    logic [WIDTH*AREG_W-1:0]  in_rs2;
    logic [WIDTH*AREG_W-1:0]  in_rd;
    logic [WIDTH*7-1:0]       in_opcode;
    logic [WIDTH*3-1:0]       in_alu_op;
    logic [WIDTH*32-1:0]      in_imm;
    logic [PHYS_REGS-1:0]     free_regs;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_lane_valid;
    logic [WIDTH*PREG_W-1:0]  out_prs1;
    logic [WIDTH*PREG_W-1:0]  out_prs2;
    logic [WIDTH*PREG_W-1:0]  out_prd;
    logic [WIDTH*PREG_W-1:0]  out_old_prd;
    logic [WIDTH*7-1:0]       out_opcode;
    logic [WIDTH*3-1:0]       out_alu_op;
    logic [WIDTH*32-1:0]      out_imm;
    logic [PREG_W:0]          free_count;

    modport master (
        output flush, in_valid, in_lane_valid, in_rs1, in_rs2, in_rd, in_opcode, in_alu_op,
               in_imm, free_regs, out_ready,
        input  in_ready, out_valid, out_lane_valid, out_prs1, out_prs2, out_prd, out_old_prd,
               out_opcode, out_alu_op, out_imm, free_count
    );

    modport slave (
        input  flush, in_valid, in_lane_valid, in_rs1, in_rs2, in_rd, in_opcode, in_alu_op,
               in_imm, free_regs, out_ready,
        output in_ready, out_valid, out_lane_valid, out_prs1, out_prs2, out_prd, out_old_prd,
               out_opcode, out_alu_op, out_imm, free_count
    );
endinterface

// File: rtl/rename_nway_free_list_alloc.sv
// Bit-vector free list: WIDTH-way lowest-index pick, commit on alloc_en, retire release OR.
module rename_nway_free_list_alloc #(
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned PHYS_REGS = 64,
    parameter int unsigned PREG_W    = $clog2(PHYS_REGS)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [WIDTH-1:0]             alloc_req,
    input  logic                         alloc_en,
    input  logic [PHYS_REGS-1:0]         release_mask,
    output logic [WIDTH-1:0][PREG_W-1:0] alloc_idx,
    output logic [PREG_W:0]              free_count
);
    logic [PHYS_REGS-1:0] free_q, free_d, taken, avail;
    logic [PREG_W:0]      count_q, count_d;
    logic                 found;

    // Each lane sees the list minus what lower requesting lanes already claimed.
    always_comb begin
        taken     = '0;
        avail     = '0;
        found     = 1'b0;
        alloc_idx = '0;
        for (int k = 0; k < WIDTH; k++) begin
            avail = free_q & ~taken;
            found = 1'b0;
            for (int i = 0; i < PHYS_REGS; i++) begin
                if (avail[i] && !found) begin
                    alloc_idx[k] = PREG_W'(i);
                    found        = 1'b1;
                    if (alloc_req[k]) taken[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        free_d = free_q;
        if (alloc_en) free_d = free_d & ~taken;
        free_d    = free_d | release_mask;
        free_d[0] = 1'b0;
        count_d   = '0;
        for (int i = 0; i < PHYS_REGS; i++) count_d = count_d + (PREG_W+1)'(free_d[i]);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < PHYS_REGS; i++) free_q[i] <= (i >= ARCH_REGS);
            count_q <= (PREG_W+1)'(PHYS_REGS - ARCH_REGS);
        end else begin
            free_q  <= free_d;
            count_q <= count_d;
        end
    end

    assign free_count = count_q;

endmodule

// File: rtl/rename_nway.sv
// N-wide register rename: speculative RAT with in-group forwarding and a registered output group.
module rename_nway
    import rename_nway_pkg::*;
#(
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned PHYS_REGS = 64,
    parameter int unsigned AREG_W    = $clog2(ARCH_REGS),
    parameter int unsigned PREG_W    = $clog2(PHYS_REGS)
) (
    input logic           clk,
    input logic           reset_n,
    rename_nway_if.slave  bus
);
    logic [ARCH_REGS-1:0][PREG_W-1:0] rat_q, rat_d;
    logic [WIDTH-1:0][PREG_W-1:0]     alloc_idx;
    logic [WIDTH-1:0]                 wr_lane;
    logic [PREG_W:0]                  free_count;
    uop_t [WIDTH-1:0]                 uop_q, uop_d;
    logic                             out_valid_q, in_ready, fire;

    assign in_ready = (!out_valid_q || bus.out_ready) && (free_count >= (PREG_W+1)'(WIDTH))
                      && !bus.flush;
    assign fire     = bus.in_valid && in_ready;

    always_comb begin
        wr_lane = '0;
        for (int k = 0; k < WIDTH; k++) begin
            wr_lane[k] = bus.in_lane_valid[k] && writes_rd(bus.in_opcode[k*7 +: 7])
                         && (bus.in_rd[k*AREG_W +: AREG_W] != '0);
        end
    end

    rename_nway_free_list_alloc #(
        .WIDTH    (WIDTH),
        .ARCH_REGS(ARCH_REGS),
        .PHYS_REGS(PHYS_REGS),
        .PREG_W   (PREG_W)
    ) u_free_list (
        .clk         (clk),
        .reset_n     (reset_n),
        .alloc_req   (wr_lane),
        .alloc_en    (fire),
        .release_mask(bus.free_regs),
        .alloc_idx   (alloc_idx),
        .free_count  (free_count)
    );

    // rat_d is updated lane by lane so later lanes see earlier lanes' new mappings.
    always_comb begin
        rat_d = rat_q;
        uop_d = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (bus.in_lane_valid[k]) begin
                uop_d[k].valid  = 1'b1;
                uop_d[k].opcode = bus.in_opcode[k*7 +: 7];
                uop_d[k].alu_op = bus.in_alu_op[k*3 +: 3];
                uop_d[k].imm    = bus.in_imm[k*32 +: 32];
                if (reads_rs1(bus.in_opcode[k*7 +: 7]))
                    uop_d[k].prs1 = rat_d[bus.in_rs1[k*AREG_W +: AREG_W]];
                if (reads_rs2(bus.in_opcode[k*7 +: 7]))
                    uop_d[k].prs2 = rat_d[bus.in_rs2[k*AREG_W +: AREG_W]];
                if (wr_lane[k]) begin
                    uop_d[k].old_prd = rat_d[bus.in_rd[k*AREG_W +: AREG_W]];
                    uop_d[k].prd     = alloc_idx[k];
                    rat_d[bus.in_rd[k*AREG_W +: AREG_W]] = alloc_idx[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < ARCH_REGS; i++) rat_q[i] <= PREG_W'(i);
            uop_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (fire) rat_q <= rat_d;
            if (bus.flush) begin
                out_valid_q <= 1'b0;
            end else if (fire) begin
                out_valid_q <= 1'b1;
                uop_q       <= uop_d;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.out_lane_valid = '0;
        bus.out_prs1       = '0;
        bus.out_prs2       = '0;
        bus.out_prd        = '0;
        bus.out_old_prd    = '0;
        bus.out_opcode     = '0;
        bus.out_alu_op     = '0;
        bus.out_imm        = '0;
        for (int k = 0; k < WIDTH; k++) begin
            bus.out_lane_valid[k]                = uop_q[k].valid;
            bus.out_prs1[k*PREG_W +: PREG_W]     = uop_q[k].prs1;
            bus.out_prs2[k*PREG_W +: PREG_W]     = uop_q[k].prs2;
            bus.out_prd[k*PREG_W +: PREG_W]      = uop_q[k].prd;
            bus.out_old_prd[k*PREG_W +: PREG_W]  = uop_q[k].old_prd;
            bus.out_opcode[k*7 +: 7]             = uop_q[k].opcode;
            bus.out_alu_op[k*3 +: 3]             = uop_q[k].alu_op;
            bus.out_imm[k*32 +: 32]              = uop_q[k].imm;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.free_count = free_count;

endmodule

// File: tb/tb_rename_nway.sv
// Directed bench for rename_nway with a reference model feeding an expected-group queue.
module tb_rename_nway;
    import rename_nway_pkg::*;

    typedef uop_t [1:0] grp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    int          m_rat [32];
    logic [63:0] m_free;
    int          m_cnt;
    bit          m_ov;
    grp_t        q [$];

    always #5 clk = ~clk;

    rename_nway_if #(.WIDTH(2), .PHYS_REGS(64), .AREG_W(5), .PREG_W(6)) bus ();

    rename_nway #(.WIDTH(2), .ARCH_REGS(32), .PHYS_REGS(64)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rat[i] = i;
        m_free = 64'hFFFF_FFFF_0000_0000;
        m_cnt  = 32;
        m_ov   = 1'b0;
        q.delete();
    endtask

    function automatic grp_t model_group();
        grp_t g;
        logic [6:0] op;
        logic [4:0] rd;
        bit wr;
        g = '0;
        for (int k = 0; k < 2; k++) begin
            op = bus.in_opcode[k*7 +: 7];
            rd = bus.in_rd[k*5 +: 5];
            if (bus.in_lane_valid[k]) begin
                g[k].valid  = 1'b1;
                g[k].opcode = op;
                g[k].alu_op = bus.in_alu_op[k*3 +: 3];
                g[k].imm    = bus.in_imm[k*32 +: 32];
                if (op == OP_RTYPE || op == OP_IALU || op == OP_LOAD || op == OP_STORE)
                    g[k].prs1 = 6'(m_rat[bus.in_rs1[k*5 +: 5]]);
                if (op == OP_RTYPE || op == OP_STORE)
                    g[k].prs2 = 6'(m_rat[bus.in_rs2[k*5 +: 5]]);
                wr = (op == OP_RTYPE || op == OP_IALU || op == OP_LOAD) && rd != 5'd0;
                if (wr) begin
                    for (int i = 1; i < 64; i++) begin
                        if (m_free[i]) begin
                            m_free[i]    = 1'b0;
                            g[k].old_prd = 6'(m_rat[rd]);
                            g[k].prd     = 6'(i);
                            m_rat[rd]    = i;
                            break;
                        end
                    end
                end
            end
        end
        return g;
    endfunction

    task automatic set_lane(input int k, input bit v, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [2:0] alu, input logic [31:0] imm);
        bus.in_lane_valid[k] = v;
        bus.in_opcode[k*7 +: 7] = op;
        bus.in_rd[k*5 +: 5]     = rd;
        bus.in_rs1[k*5 +: 5]    = rs1;
        bus.in_rs2[k*5 +: 5]    = rs2;
        bus.in_alu_op[k*3 +: 3] = alu;
        bus.in_imm[k*32 +: 32]  = imm;
    endtask

    // One clock: check in_ready, model the edge, then compare registered outputs.
    task automatic step();
        bit   exp_rdy;
        bit   fire;
        grp_t e;
        #1;
        exp_rdy = (!m_ov || bus.out_ready) && m_cnt >= 2 && !bus.flush;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        fire = reset_n && bus.in_valid && exp_rdy;
        if (fire) q.push_back(model_group());
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            if (m_ov && (bus.out_ready || bus.flush)) void'(q.pop_front());
            if (bus.flush) m_ov = 1'b0;
            else if (fire) m_ov = 1'b1;
            else if (bus.out_ready) m_ov = 1'b0;
            m_free = (m_free | bus.free_regs) & ~64'd1;
            m_cnt  = $countones(m_free);
        end
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
        chk("free_count", 32'(bus.free_count), 32'(m_cnt));
        if (m_ov && q.size() > 0) begin
            e = q[0];
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("L%0d_valid", k), 32'(bus.out_lane_valid[k]), 32'(e[k].valid));
                chk($sformatf("L%0d_prs1", k), 32'(bus.out_prs1[k*6 +: 6]), 32'(e[k].prs1));
                chk($sformatf("L%0d_prs2", k), 32'(bus.out_prs2[k*6 +: 6]), 32'(e[k].prs2));
                chk($sformatf("L%0d_prd", k), 32'(bus.out_prd[k*6 +: 6]), 32'(e[k].prd));
                chk($sformatf("L%0d_old", k), 32'(bus.out_old_prd[k*6 +: 6]), 32'(e[k].old_prd));
                chk($sformatf("L%0d_op", k), 32'(bus.out_opcode[k*7 +: 7]), 32'(e[k].opcode));
                chk($sformatf("L%0d_alu", k), 32'(bus.out_alu_op[k*3 +: 3]), 32'(e[k].alu_op));
                chk($sformatf("L%0d_imm", k), bus.out_imm[k*32 +: 32], e[k].imm);
            end
        end
        bus.free_regs = '0;
        bus.flush     = 1'b0;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        reset_n      = 1'b0;
        step();
        reset_n      = 1'b1;
    endtask

    initial begin
        reset_n           = 1'b0;
        bus.flush         = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_lane_valid = '0;
        bus.in_rs1        = '0;
        bus.in_rs2        = '0;
        bus.in_rd         = '0;
        bus.in_opcode     = '0;
        bus.in_alu_op     = '0;
        bus.in_imm        = '0;
        bus.free_regs     = '0;
        bus.out_ready     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_free_count", 32'(bus.free_count), 32'd32);
        chk("rst_out_prd", 32'(bus.out_prd), 32'd0);
        chk("rst_out_imm", bus.out_imm[31:0], 32'd0);

        // ADD x3=x1+x2 ; ADDI x4=x3+5 (forwarded source)
        set_lane(0, 1, OP_RTYPE, 5'd3, 5'd1, 5'd2, 3'd0, 32'd0);
        set_lane(1, 1, OP_IALU, 5'd4, 5'd3, 5'd0, 3'd1, 32'd5);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("t1_l0_prd", 32'(bus.out_prd[5:0]), 32'd32);
        chk("t1_l0_old", 32'(bus.out_old_prd[5:0]), 32'd3);
        chk("t1_l1_prs1", 32'(bus.out_prs1[11:6]), 32'd32);
        chk("t1_l1_prd", 32'(bus.out_prd[11:6]), 32'd33);
        chk("t1_count", 32'(bus.free_count), 32'd30);
        step();

        // Same rd in both lanes
        do_reset();
        set_lane(0, 1, OP_IALU, 5'd5, 5'd1, 5'd0, 3'd2, 32'd7);
        set_lane(1, 1, OP_LOAD, 5'd5, 5'd5, 5'd0, 3'd0, 32'd16);
        bus.in_valid = 1'b1;
        step();
        chk("t2_l1_old", 32'(bus.out_old_prd[11:6]), 32'd32);
        chk("t2_l1_prd", 32'(bus.out_prd[11:6]), 32'd33);
        set_lane(0, 1, OP_RTYPE, 5'd6, 5'd5, 5'd5, 3'd0, 32'd0);
        set_lane(1, 0, OP_RTYPE, 5'd7, 5'd1, 5'd1, 3'd0, 32'd0);
        step();
        bus.in_valid = 1'b0;
        chk("t2_rat5", 32'(bus.out_prs1[5:0]), 32'd33);
        chk("t2_inv_lane", 32'(bus.out_opcode[13:7]), 32'd0);
        step();

        // Store plus rd=x0 writer; releasing free bits and bit 0 changes nothing
        do_reset();
        set_lane(0, 1, OP_STORE, 5'd9, 5'd1, 5'd2, 3'd0, 32'd8);
        set_lane(1, 1, OP_IALU, 5'd0, 5'd1, 5'd0, 3'd0, 32'd1);
        bus.in_valid  = 1'b1;
        bus.free_regs = 64'h0000_0100_0000_0001;
        step();
        bus.in_valid = 1'b0;
        chk("t3_sw_prd", 32'(bus.out_prd[5:0]), 32'd0);
        chk("t3_x0_prd", 32'(bus.out_prd[11:6]), 32'd0);
        chk("t3_sw_prs2", 32'(bus.out_prs2[5:0]), 32'd2);
        chk("t3_count", 32'(bus.free_count), 32'd32);
        step();

        // Exhaust the free list, then refill from retire
        bus.in_valid = 1'b1;
        for (int g = 0; g < 16; g++) begin
            set_lane(0, 1, OP_IALU, 5'((2 * g) % 31 + 1), 5'(g), 5'd0, 3'(g), 32'(g));
            set_lane(1, 1, OP_RTYPE, 5'((2 * g + 1) % 31 + 1), 5'(g), 5'(g + 1), 3'd0, 32'd0);
            step();
            if (g == 14) chk("t4_count15", 32'(bus.free_count), 32'd2);
        end
        chk("t4_count16", 32'(bus.free_count), 32'd0);
        bus.free_regs = (64'd1 << 40) | (64'd1 << 45);
        step();
        chk("t4_ready_back", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("t4_l0_prd", 32'(bus.out_prd[5:0]), 32'd40);
        chk("t4_l1_prd", 32'(bus.out_prd[11:6]), 32'd45);

        // Stall with a pending group, then flush
        bus.free_regs = (64'd1 << 50) | (64'd1 << 51);
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        step();
        bus.free_regs = (64'd1 << 52) | (64'd1 << 53);
        step();
        chk("t5_hold_prd", 32'(bus.out_prd[5:0]), 32'd50);
        step();
        chk("t5_hold_prd2", 32'(bus.out_prd[5:0]), 32'd50);
        bus.flush = 1'b1;
        step();
        chk("t5_flush_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_flush_count", 32'(bus.free_count), 32'd2);

        // Fire with out_ready low, then reset mid-stall
        step();
        chk("t6_pending", 32'(bus.out_valid), 32'd1);
        do_reset();
        chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_rst_count", 32'(bus.free_count), 32'd32);
        bus.out_ready = 1'b1;
        set_lane(0, 1, OP_RTYPE, 5'd7, 5'd5, 5'd6, 3'd0, 32'd0);
        set_lane(1, 1, OP_STORE, 5'd0, 5'd3, 5'd4, 3'd0, 32'd4);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("t6_rat5", 32'(bus.out_prs1[5:0]), 32'd5);
        chk("t6_rat6", 32'(bus.out_prs2[5:0]), 32'd6);
        chk("t6_rat4", 32'(bus.out_prs2[11:6]), 32'd4);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
